// File: rtl/mmu_pkg.sv
// mmu_pkg: state encoding and index width shared by the
// memory-instruction sequencer and its wait timer.
package mmu_pkg;

  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [1:0]       state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_RDREG  = 2'd1;
  localparam state_t S_MEMREQ = 2'd2;
  localparam state_t S_WB     = 2'd3;

endpackage

// File: rtl/mmu_wait_timer.sv
// mmu_wait_timer: 8-bit wait counter for an outstanding memory
// request; expired marks the last cycle a request may stay open.
module mmu_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mmu_sequencer.sv
// mmu_sequencer: runs one decoded load/store through register
// read, memory request/ack and register write-back.
module mmu_sequencer
  import mmu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ld,
  input  logic              cmd_st,
  input  logic [IDX_W-1:0]  cmd_reg_addr,
  input  logic [IDX_W-1:0]  cmd_mem_addr,
  output logic              rf_rd_en,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_invalid,
  output logic              err_timeout
);

  state_t            state_q, state_d;
  logic              st_q, st_d;
  idx_t              reg_q, reg_d;
  idx_t              maddr_q, maddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              einv_q, einv_d;
  logic              eto_q, eto_d;
  logic              tmr_clr, tmr_en, tmr_exp;

  mmu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    reg_d   = reg_q;
    maddr_d = maddr_q;
    data_d  = data_q;
    einv_d  = 1'b0;
    eto_d   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          st_d    = cmd_st;
          reg_d   = cmd_reg_addr;
          maddr_d = cmd_mem_addr;
          unique case (1'b1)
            cmd_st && !cmd_ld: state_d = S_RDREG;
            cmd_ld && !cmd_st: begin
              state_d = S_MEMREQ;
              tmr_clr = 1'b1;
            end
            default: einv_d = 1'b1;
          endcase
        end
      end
      S_RDREG: begin
        data_d  = rf_rd_data;
        state_d = S_MEMREQ;
        tmr_clr = 1'b1;
      end
      S_MEMREQ: begin
        // an ack arriving on the expiry cycle still completes
        if (mem_ack) begin
          if (st_q) begin
            state_d = S_IDLE;
          end else begin
            data_d  = mem_rdata;
            state_d = S_WB;
          end
        end else if (tmr_exp) begin
          state_d = S_IDLE;
          eto_d   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= 1'b0;
      reg_q   <= '0;
      maddr_q <= '0;
      data_q  <= '0;
      einv_q  <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      reg_q   <= reg_d;
      maddr_q <= maddr_d;
      data_q  <= data_d;
      einv_q  <= einv_d;
      eto_q   <= eto_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = !cmd_ready;
  assign rf_rd_en    = (state_q == S_RDREG);
  assign rf_rd_addr  = rf_rd_en ? reg_q : '0;
  assign rf_wr_en    = (state_q == S_WB);
  assign rf_wr_addr  = rf_wr_en ? reg_q : '0;
  assign rf_wr_data  = rf_wr_en ? data_q : '0;
  assign mem_req     = (state_q == S_MEMREQ);
  assign mem_we      = mem_req & st_q;
  assign mem_addr    = mem_req ? maddr_q : '0;
  assign mem_wdata   = mem_req ? data_q : '0;
  assign err_invalid = einv_q;
  assign err_timeout = eto_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer: randomized bench with a behavioural RF/memory
// model and per-command latency/effect predictions.
module tb_mmu_sequencer;

  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic          cmd_ld = 1'b0, cmd_st = 1'b0;
  logic [3:0]    cmd_reg_addr = '0, cmd_mem_addr = '0;
  logic          rf_rd_en, rf_wr_en, mem_req, mem_we;
  logic [3:0]    rf_rd_addr, rf_wr_addr, mem_addr;
  logic [DW-1:0] rf_rd_data, rf_wr_data, mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, err_invalid, err_timeout;

  always #5 clk = ~clk;

  mmu_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld), .cmd_st(cmd_st),
    .cmd_reg_addr(cmd_reg_addr), .cmd_mem_addr(cmd_mem_addr),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy),
    .err_invalid(err_invalid), .err_timeout(err_timeout)
  );

  logic [DW-1:0] rf  [16];
  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_rf  [16];
  logic [DW-1:0] exp_mem [16];

  int ack_after = 0;
  int req_cnt = 0;
  int n_req = 0, n_rd = 0, n_wr = 0;
  int n_inv = 0, n_to = 0, n_bad = 0;
  logic [3:0]    wr_addr_seen = '0;
  logic [DW-1:0] wr_data_seen = '0;
  int passed = 0, total = 0;

  assign rf_rd_data = rf[rf_rd_addr];

  // memory/RF responder: commits writes at the edge, then
  // presents ack/rdata for the new cycle
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack && mem_we)
      mem[mem_addr] = mem_wdata;
    if (rst_n && rf_wr_en)
      rf[rf_wr_addr] = rf_wr_data;
    #1;
    if (mem_req) begin
      mem_ack = (ack_after >= 0) && (req_cnt == ack_after);
      mem_rdata = mem_ack ? mem[mem_addr] : $urandom;
      req_cnt++;
    end else begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      req_cnt = 0;
    end
  end

  always @(posedge clk) begin
    #3;
    if (rst_n) begin
      if (mem_req) n_req++;
      if (rf_rd_en) n_rd++;
      if (rf_wr_en) begin
        n_wr++;
        wr_addr_seen = rf_wr_addr;
        wr_data_seen = rf_wr_data;
      end
      if (err_invalid) n_inv++;
      if (err_timeout) n_to++;
      if (cmd_ready !== !(mem_req | rf_rd_en | rf_wr_en))
        n_bad++;
    end
  end

  task automatic clr_counts();
    n_req = 0; n_rd = 0; n_wr = 0;
    n_inv = 0; n_to = 0; n_bad = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // issue one command at a negedge; lat = cycles until ready again
  task automatic send(input logic ld, input logic st,
                      input logic [3:0] r, input logic [3:0] m,
                      output int lat);
    int k;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk); k++;
    end
    cmd_valid = 1'b1; cmd_ld = ld; cmd_st = st;
    cmd_reg_addr = r; cmd_mem_addr = m;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!cmd_ready && lat < 100) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({cmd_ready, busy, rf_rd_en, rf_wr_en, mem_req, mem_we,
         err_invalid, err_timeout} !== 8'b1000_0000)
      $display("FAIL reset_ctrl: got %b want 10000000",
        {cmd_ready, busy, rf_rd_en, rf_wr_en, mem_req, mem_we,
         err_invalid, err_timeout});
    else passed++;
    total++;
    if ({rf_rd_addr, rf_wr_addr, mem_addr, rf_wr_data, mem_wdata}
        !== '0)
      $display("FAIL reset_data: got nonzero want 0");
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_store();
    rf[3] = 32'hDEADBEEF;
    ack_after = 0;
    clr_counts();
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_st = 1'b1;
    cmd_reg_addr = 4'd3; cmd_mem_addr = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({rf_rd_en, rf_rd_addr, mem_req} !== {1'b1, 4'd3, 1'b0})
      $display("FAIL store_c1: got en=%b addr=%0d req=%b want 1 3 0",
        rf_rd_en, rf_rd_addr, mem_req);
    else passed++;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 4'd5, 32'hDEADBEEF})
      $display("FAIL store_c2: got req=%b we=%b a=%0d d=%h",
        mem_req, mem_we, mem_addr, mem_wdata);
    else passed++;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || mem[5] !== 32'hDEADBEEF)
      $display("FAIL store_c3: got ready=%b mem5=%h want 1 deadbeef",
        cmd_ready, mem[5]);
    else passed++;
    idle(1);
  endtask

  task automatic test_load();
    int lat;
    mem[9] = 32'h1234;
    ack_after = 4;
    clr_counts();
    send(1'b1, 1'b0, 4'd7, 4'd9, lat);
    idle(2);
    total++;
    if (lat != 7)
      $display("FAIL load_latency: got %0d want 7", lat);
    else passed++;
    total++;
    if (n_wr != 1 || wr_addr_seen !== 4'd7 ||
        wr_data_seen !== 32'h1234)
      $display("FAIL load_wb: got n=%0d a=%0d d=%h want 1 7 1234",
        n_wr, wr_addr_seen, wr_data_seen);
    else passed++;
    total++;
    if (n_req != 5 || n_rd != 0)
      $display("FAIL load_req: got req=%0d rd=%0d want 5 0",
        n_req, n_rd);
    else passed++;
  endtask

  task automatic test_invalid();
    int lat;
    clr_counts();
    send(1'b0, 1'b0, 4'd1, 4'd2, lat);
    total++;
    if (lat != 1) $display("FAIL inv_lat: got %0d want 1", lat);
    else passed++;
    send(1'b1, 1'b1, 4'd1, 4'd2, lat);
    idle(2);
    total++;
    if (n_inv != 2)
      $display("FAIL inv_count: got %0d want 2", n_inv);
    else passed++;
    total++;
    if (n_rd + n_wr + n_req != 0)
      $display("FAIL inv_activity: got %0d want 0",
        n_rd + n_wr + n_req);
    else passed++;
  endtask

  task automatic test_timeout();
    int lat;
    ack_after = -1;
    clr_counts();
    send(1'b1, 1'b0, 4'd2, 4'd4, lat);
    idle(2);
    total++;
    if (n_req != TO || n_to != 1 || n_wr != 0 || lat != TO + 1)
      $display("FAIL timeout: got req=%0d to=%0d wr=%0d lat=%0d",
        n_req, n_to, n_wr, lat);
    else passed++;
    ack_after = TO - 1;
    mem[4] = 32'hCAFE0001;
    clr_counts();
    send(1'b1, 1'b0, 4'd2, 4'd4, lat);
    idle(2);
    total++;
    if (n_req != TO || n_to != 0 || n_wr != 1 || lat != TO + 2 ||
        rf[2] !== 32'hCAFE0001)
      $display("FAIL late_ack: got req=%0d to=%0d wr=%0d lat=%0d",
        n_req, n_to, n_wr, lat);
    else passed++;
  endtask

  task automatic test_reset_mid();
    ack_after = -1;
    clr_counts();
    cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_st = 1'b0;
    cmd_reg_addr = 4'd6; cmd_mem_addr = 4'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    idle(3);
    total++;
    if (mem_req !== 1'b1)
      $display("FAIL rstmid_pre: got req=%b want 1", mem_req);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL rstmid_async: got req=%b rdy=%b want 0 1",
        mem_req, cmd_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    ack_after = 0;
    idle(4);
    total++;
    if (n_wr != 0 || cmd_ready !== 1'b1)
      $display("FAIL rstmid_post: got wr=%0d rdy=%b want 0 1",
        n_wr, cmd_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int acc, cyc;
    ack_after = 0;
    clr_counts();
    cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_st = 1'b0;
    cmd_reg_addr = 4'd8; cmd_mem_addr = 4'd3;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 50) begin
      if (cmd_ready) acc++;
      @(negedge clk); cyc++;
    end
    cmd_valid = 1'b0;
    idle(4);
    total++;
    if (cyc != 7)
      $display("FAIL b2b_cycles: got %0d want 7", cyc);
    else passed++;
    total++;
    if (n_req != 3 || n_wr != 3 || n_bad != 0)
      $display("FAIL b2b_seq: got req=%0d wr=%0d bad=%0d want 3 3 0",
        n_req, n_wr, n_bad);
    else passed++;
  endtask

  task automatic test_random();
    int lat, elat, w, aa, sel;
    int e_req, e_wr, e_inv, e_to;
    logic ld, st, tmo;
    logic [3:0] r, m;
    for (int i = 0; i < 16; i++) begin
      rf[i] = $urandom; mem[i] = $urandom;
      exp_rf[i] = rf[i]; exp_mem[i] = mem[i];
    end
    clr_counts();
    e_req = 0; e_wr = 0; e_inv = 0; e_to = 0;
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) st = !ld;
      r = 4'($urandom); m = 4'($urandom);
      sel = $urandom_range(0, 9);
      aa = (sel <= 5) ? sel : (sel == 6) ? TO - 1 :
           (sel == 7) ? TO : (sel == 8) ? -1 : 0;
      ack_after = aa;
      tmo = (aa < 0) || (aa >= TO);
      w = tmo ? TO : aa + 1;
      if (ld == st) begin
        elat = 1; e_inv++;
      end else if (st) begin
        elat = w + 2; e_req += w;
        if (tmo) e_to++;
        else exp_mem[m] = exp_rf[r];
      end else begin
        elat = w + (tmo ? 1 : 2); e_req += w;
        if (tmo) e_to++;
        else begin exp_rf[r] = exp_mem[m]; e_wr++; end
      end
      send(ld, st, r, m, lat);
      total++;
      if (lat != elat)
        $display("FAIL rnd_lat[%0d]: got %0d want %0d ld=%b st=%b",
          n, lat, elat, ld, st);
      else passed++;
      idle($urandom_range(0, 2));
    end
    idle(3);
    total++;
    if (n_req != e_req || n_wr != e_wr || n_inv != e_inv ||
        n_to != e_to || n_bad != 0)
      $display("FAIL rnd_counts: got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/0",
        n_req, n_wr, n_inv, n_to, n_bad, e_req, e_wr, e_inv, e_to);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rf[i] !== exp_rf[i] || mem[i] !== exp_mem[i])
        $display("FAIL rnd_state[%0d]: got rf=%h mem=%h want %h %h",
          i, rf[i], mem[i], exp_rf[i], exp_mem[i]);
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i] = '0; mem[i] = '0;
    end
    test_reset();
    test_store();
    test_load();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
